block_b_mgs_core: RTL and testbench

// - Block B front end of the OMP/MGS reconstruction datapath: on start_b, fetches

---
 rtl/omp_pkg.sv | 26 ++
 rtl/block_b_mgs_core_buf.sv | 41 ++++
 rtl/block_b_mgs_core.sv | 133 +++++++++++++
 tb/tb_block_b_mgs_core.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/omp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : omp_pkg
//  Description : Shared constants for the OMP/MGS reconstruction datapath:
//                Phi element/word geometry, column/word index widths and the
//                Block B state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package omp_pkg;

  localparam int ELEM_W = 24;               // one signed fixed-point Phi element
  localparam int LANES  = 4;                // elements per BRAM word
  localparam int COL_W  = 6;                // column index width (64 columns)
  localparam int WIDX_W = 3;                // word-in-column index width

  localparam int DATA_W = ELEM_W * LANES;   // 96-bit BRAM word
  localparam int ADDR_W = COL_W + WIDX_W;   // 9-bit BRAM address
  localparam int NWORDS = 1 << WIDX_W;      // words held by the column buffer

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;

endpackage : omp_pkg
`default_nettype wire

// File: rtl/block_b_mgs_core_buf.sv
`default_nettype none
// ============================================================================
//  Module      : mgs_col_buf
//  Description : 8 x 96-bit column register file for the MGS stage.
//                Synchronous write, synchronous clear of all words,
//                combinational read.
//  Ports       : clk, rst      - clock / sync active-high reset
//                i_clr         - clear every word to zero (wins over write)
//                i_we, i_waddr, i_wdata - write port
//                i_raddr, o_rdata       - combinational read port
//  Revision    : 1.0 - initial release
// ============================================================================
module mgs_col_buf
  import omp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [WIDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [WIDX_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NWORDS];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < NWORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : mgs_col_buf
`default_nettype wire

// File: rtl/block_b_mgs_core.sv
`default_nettype none
// ============================================================================
//  Module      : block_b_mgs_core
//  Description : Block B front end. On a start request, fetches one Phi
//                column (M_limit+1 words of 4 x 24-bit elements) from a
//                1-cycle-latency synchronous BRAM into a column buffer.
//  Ports       : clk, rst        - clock / sync active-high reset
//                i_start_b       - load request, honoured only in IDLE
//                i_lambda        - column index to load
//                i_m_limit       - last word index of the column
//                o_phi_addr      - registered BRAM address {lambda, word}
//                i_phi_data      - BRAM read data
//                o_state_out     - current FSM state code
//                o_done_b        - one-cycle pulse when the column is loaded
//                i_col_rd_addr   - buffer read index
//                o_col_rd_data   - buffer word, combinational read
//  Revision    : 1.0 - initial release
// ============================================================================
module block_b_mgs_core
  import omp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start_b,
  input  logic [COL_W-1:0]  i_lambda,
  input  logic [WIDX_W-1:0] i_m_limit,
  output logic [ADDR_W-1:0] o_phi_addr,
  input  logic [DATA_W-1:0] i_phi_data,
  output logic [2:0]        o_state_out,
  output logic              o_done_b,
  input  logic [WIDX_W-1:0] i_col_rd_addr,
  output logic [DATA_W-1:0] o_col_rd_data
);

  logic [2:0]        r_state;
  logic [COL_W-1:0]  r_lambda;
  logic [WIDX_W-1:0] r_mlim;
  logic [WIDX_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_phi_addr;
  logic              r_done;

  // Capture pipeline: stage 1 tracks the index just placed on o_phi_addr,
  // stage 2 tracks the index whose BRAM data is on i_phi_data this cycle.
  logic              r_v1;
  logic [WIDX_W-1:0] r_idx1;
  logic              r_v2;
  logic [WIDX_W-1:0] r_idx2;

  logic              w_start;
  logic              w_last_wr;
  logic [WIDX_W-1:0] w_cnt_nxt;

  assign w_start   = (r_state == ST_IDLE) && i_start_b;
  assign w_last_wr = r_v2 && (r_idx2 == r_mlim);
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lambda   <= '0;
      r_mlim     <= '0;
      r_cnt      <= '0;
      r_phi_addr <= '0;
      r_done     <= 1'b0;
      r_v1       <= 1'b0;
      r_idx1     <= '0;
      r_v2       <= 1'b0;
      r_idx2     <= '0;
    end else begin
      r_done <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= r_v1;
      r_idx2 <= r_idx1;
      case (r_state)
        ST_IDLE: begin
          if (i_start_b) begin
            r_lambda   <= i_lambda;
            r_mlim     <= i_m_limit;
            r_cnt      <= '0;
            r_phi_addr <= {i_lambda, {WIDX_W{1'b0}}};
            r_v1       <= 1'b1;
            r_idx1     <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Word 0 was issued on the accepting edge, so a single-word load
          // has nothing left to issue here.
          if (r_cnt == r_mlim) begin
            r_state <= ST_WAIT;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_phi_addr <= {r_lambda, w_cnt_nxt};
            r_v1       <= 1'b1;
            r_idx1     <= w_cnt_nxt;
            if (w_cnt_nxt == r_mlim) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_last_wr) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  mgs_col_buf u_col_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_we    (r_v2),
    .i_waddr (r_idx2),
    .i_wdata (i_phi_data),
    .i_raddr (i_col_rd_addr),
    .o_rdata (o_col_rd_data)
  );

  assign o_phi_addr  = r_phi_addr;
  assign o_state_out = r_state;
  assign o_done_b    = r_done;

endmodule : block_b_mgs_core
`default_nettype wire

// File: tb/tb_block_b_mgs_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_b_mgs_core
//  Description : Self-checking bench for block_b_mgs_core with a 1-cycle BRAM
//                model returning {4{15'd0, addr}} and a column-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_block_b_mgs_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_b;
  logic [5:0]  lambda;
  logic [2:0]  m_limit;
  logic [8:0]  phi_addr;
  logic [95:0] phi_data;
  logic [2:0]  state_out;
  logic        done_b;
  logic [2:0]  col_rd_addr;
  logic [95:0] col_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  always @(posedge clk) phi_data <= {4{15'd0, phi_addr}};

  block_b_mgs_core dut (
    .clk           (clk),
    .rst           (rst),
    .i_start_b     (start_b),
    .i_lambda      (lambda),
    .i_m_limit     (m_limit),
    .o_phi_addr    (phi_addr),
    .i_phi_data    (phi_data),
    .o_state_out   (state_out),
    .o_done_b      (done_b),
    .i_col_rd_addr (col_rd_addr),
    .o_col_rd_data (col_rd_data)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected column: word i holds row address lambda*8+i in each lane for
  // i <= mlim, all other words zero.
  task automatic check_buf(input string tag, input int lam, input int ml, input bit all_zero);
    logic [95:0] exp;
    for (int i = 0; i < 8; i++) begin
      col_rd_addr = 3'(i);
      #1;
      exp = (!all_zero && i <= ml) ? {4{24'(lam * 8 + i)}} : 96'd0;
      chk(tag, col_rd_data, exp);
    end
  endtask

  task automatic run_load(input int lam, input int ml, input bit repulse);
    logic [8:0] addrs[$];
    int n, ndone, done_at;
    bit fin;
    @(negedge clk);
    start_b = 1'b1; lambda = 6'(lam); m_limit = 3'(ml);
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    lambda  = 6'($urandom);
    m_limit = 3'($urandom);
    addrs.push_back(phi_addr);
    n = 0; ndone = 0; done_at = -1; fin = 1'b0;
    while (!fin && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_b = repulse && (n == 2);
      if (start_b) lambda = 6'd5;
      chk("state_range", 96'(state_out <= 3'd3), 96'd1);
      if (phi_addr != addrs[$]) addrs.push_back(phi_addr);
      if (done_b) begin
        ndone++;
        done_at = n;
      end
      if (state_out == 3'd0) fin = 1'b1;
    end
    start_b = 1'b0;
    chk("load_timeout", 96'(fin), 96'd1);
    chk("done_count", 96'(ndone), 96'(1));
    chk("done_cycle", 96'(done_at), 96'(ml + 2));
    chk("addr_count", 96'(addrs.size()), 96'(ml + 1));
    for (int i = 0; i < addrs.size() && i <= ml; i++)
      chk("addr_seq", 96'(addrs[i]), 96'(lam * 8 + i));
    check_buf("buf_load", lam, ml, 1'b0);
  endtask

  initial begin
    int cyc, ndone;
    rst = 1'b1; start_b = 1'b0; lambda = '0; m_limit = '0; col_rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 96'(state_out), 96'd0);
    chk("rst_addr", 96'(phi_addr), 96'd0);
    chk("rst_done", 96'(done_b), 96'd0);
    check_buf("rst_buf", 0, 0, 1'b1);

    run_load(10, 7, 1'b0);
    run_load(50, 1, 1'b0);
    run_load(63, 0, 1'b0);
    run_load(10, 7, 1'b1);

    // Reset while waiting for the last BRAM words.
    @(negedge clk);
    start_b = 1'b1; lambda = 6'd10; m_limit = 3'd7;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (state_out != 3'd2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_wait", 96'(state_out), 96'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", 96'(state_out), 96'd0);
    chk("midrst_addr", 96'(phi_addr), 96'd0);
    chk("midrst_done", 96'(done_b), 96'd0);
    check_buf("midrst_buf", 0, 0, 1'b1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_b) ndone++;
    end
    chk("midrst_nodone", 96'(ndone), 96'd0);
    run_load(7, 3, 1'b0);

    for (int k = 0; k < 6; k++)
      run_load(int'($urandom_range(63, 0)), int'($urandom_range(7, 0)), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_block_b_mgs_core
`default_nettype wire
